// File: rtl/rv_pkg.sv
// Shared RV32 definitions: operand width, ALU op encoding, mul/div sequencer states.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int CTRLSIGW_W = 4;

  localparam logic [XLEN-1:0] ZERO = '0;

  // Base ops occupy codes 0-7; every M-extension op has bit 3 set.
  typedef enum logic [CTRLSIGW_W-1:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLT    = 4'd5,
    ALU_SLL    = 4'd6,
    ALU_ILL    = 4'd7,
    ALU_MUL    = 4'd8,
    ALU_MULH   = 4'd9,
    ALU_MULHSU = 4'd10,
    ALU_MULHU  = 4'd11,
    ALU_DIV    = 4'd12,
    ALU_DIVU   = 4'd13,
    ALU_REM    = 4'd14,
    ALU_REMU   = 4'd15
  } alu_op_e;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIN,
    DONE
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_dp.sv
// Mul/div datapath: operand capture, magnitude prep, one-bit-per-cycle
// shift-add multiply / restoring divide, sign fix and result register.
module muldiv_dp #(
  parameter int XLEN       = 32,
  parameter int CTRLSIGW_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_ops,
  input  logic                  prep,
  input  logic                  calc,
  input  logic                  fin,
  input  logic [CTRLSIGW_W-1:0] alu_op,
  input  logic [XLEN-1:0]       oprnd_a,
  input  logic [XLEN-1:0]       oprnd_b,
  output logic                  special,
  output logic [XLEN-1:0]       result,
  output logic                  illegal
);
  import rv_pkg::*;

  alu_op_e           op_r;
  logic [XLEN-1:0]   a_r;
  logic [XLEN-1:0]   b_r;
  logic [XLEN-1:0]   mag_r;   // multiplicand or divisor magnitude
  logic [XLEN-1:0]   hi_r;    // product high half / partial remainder
  logic [XLEN-1:0]   lo_r;    // multiplier being consumed / dividend becoming quotient

  logic              is_m, is_div, sgn_a, sgn_b, div_zero, div_ovf;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [XLEN-1:0]   hi_nx, lo_nx, res_nx, spec_res;
  logic [2*XLEN-1:0] prod_fix;

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic logic [XLEN-1:0] abs_val(input logic signed [XLEN-1:0] v,
                                              input logic is_signed);
    return (is_signed && (v < 0)) ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_p(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Op decode, special-case detection and the per-cycle iteration step.
  always_comb begin
    is_m     = op_r inside {[ALU_MUL:ALU_REMU]};
    is_div   = op_r inside {[ALU_DIV:ALU_REMU]};
    sgn_a    = (op_r inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM}) && a_r[XLEN-1];
    sgn_b    = (op_r inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM}) && b_r[XLEN-1];
    div_zero = is_div && (b_r == '0);
    div_ovf  = (op_r inside {ALU_DIV, ALU_REM}) &&
               (a_r == {1'b1, {(XLEN-1){1'b0}}}) && (b_r == '1);
    special  = !is_m || div_zero || div_ovf;

    mul_sum   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mag_r} : '0);
    div_shift = {hi_r, lo_r[XLEN-1]};
    div_diff  = div_shift - {1'b0, mag_r};
    if (is_div) begin
      if (!div_diff[XLEN]) begin
        hi_nx = div_diff[XLEN-1:0];
        lo_nx = {lo_r[XLEN-2:0], 1'b1};
      end else begin
        hi_nx = div_shift[XLEN-1:0];
        lo_nx = {lo_r[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nx = mul_sum[XLEN:1];
      lo_nx = {mul_sum[0], lo_r[XLEN-1:1]};
    end

    if (!is_m)
      spec_res = ZERO;
    else if (div_zero)
      spec_res = (op_r inside {ALU_DIV, ALU_DIVU}) ? '1 : a_r;
    else
      spec_res = (op_r == ALU_DIV) ? a_r : '0;

    prod_fix = neg_p({hi_r, lo_r}, sgn_a ^ sgn_b);
    case (op_r)
      ALU_MUL:             res_nx = prod_fix[XLEN-1:0];
      ALU_DIV, ALU_DIVU:   res_nx = neg_w(lo_r, sgn_a ^ sgn_b);
      ALU_REM, ALU_REMU:   res_nx = neg_w(hi_r, sgn_a);
      default:             res_nx = prod_fix[2*XLEN-1:XLEN];
    endcase
    if (special)
      res_nx = spec_res;
  end

  // Operand capture, iteration registers, result and illegal flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r    <= ALU_ADD;
      a_r     <= '0;
      b_r     <= '0;
      mag_r   <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      result  <= '0;
      illegal <= 1'b0;
    end else begin
      if (ld_ops) begin
        op_r    <= alu_op_e'(alu_op);
        a_r     <= oprnd_a;
        b_r     <= oprnd_b;
        illegal <= 1'b0;
      end
      if (prep) begin
        mag_r <= is_div ? abs_val(b_r, sgn_b) : abs_val(a_r, sgn_a);
        lo_r  <= is_div ? abs_val(a_r, sgn_a) : abs_val(b_r, sgn_b);
        hi_r  <= '0;
      end
      if (calc) begin
        hi_r <= hi_nx;
        lo_r <= lo_nx;
      end
      if (fin) begin
        result  <= res_nx;
        illegal <= !is_m;
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M sequencer: FSM and bit counter driving muldiv_dp.
module muldiv_seq #(
  parameter int XLEN       = 32,
  parameter int CTRLSIGW_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  flush,
  input  logic [CTRLSIGW_W-1:0] alu_op,
  input  logic [XLEN-1:0]       oprnd_a,
  input  logic [XLEN-1:0]       oprnd_b,
  output logic                  busy,
  output logic                  done,
  output logic [XLEN-1:0]       result,
  output logic                  illegal
);
  import rv_pkg::*;

  localparam int CNT_W = $clog2(XLEN);

  muldiv_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             ld_ops, prep, calc, fin, special;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and datapath strobes; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    ld_ops  = 1'b0;
    prep    = 1'b0;
    calc    = 1'b0;
    fin     = 1'b0;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    case (state_q)
      IDLE: if (start) begin
        state_d = PREP;
        ld_ops  = 1'b1;
      end
      PREP: begin
        state_d = special ? FIN : CALC;
        prep    = 1'b1;
      end
      CALC: begin
        calc = 1'b1;
        if (cnt_q == '0) state_d = FIN;
      end
      FIN: begin
        state_d = DONE;
        fin     = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      ld_ops  = 1'b0;
      prep    = 1'b0;
      calc    = 1'b0;
      fin     = 1'b0;
    end
  end

  // Iteration counter: loaded in PREP, counts XLEN-1 down to 0 in CALC.
  always_ff @(posedge clk) begin
    if (rst)       cnt_q <= '0;
    else if (prep) cnt_q <= CNT_W'(XLEN - 1);
    else if (calc) cnt_q <= cnt_q - 1'b1;
  end

  muldiv_dp #(
    .XLEN       (XLEN),
    .CTRLSIGW_W (CTRLSIGW_W)
  ) u_dp (
    .clk     (clk),
    .rst     (rst),
    .ld_ops  (ld_ops),
    .prep    (prep),
    .calc    (calc),
    .fin     (fin),
    .alu_op  (alu_op),
    .oprnd_a (oprnd_a),
    .oprnd_b (oprnd_b),
    .special (special),
    .result  (result),
    .illegal (illegal)
  );

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a queue of expected completions.
module tb_muldiv_seq;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  alu_op = 4'd0;
  logic [31:0] oprnd_a = '0;
  logic [31:0] oprnd_b = '0;
  logic        busy, done, illegal;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(32), .CTRLSIGW_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .flush   (flush),
    .alu_op  (alu_op),
    .oprnd_a (oprnd_a),
    .oprnd_b (oprnd_b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .illegal (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present an op in an idle cycle; returns inside cycle 1 after acceptance.
  task automatic start_op(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    next_cycle();
    start = 1'b1; alu_op = op; oprnd_a = a; oprnd_b = b;
    next_cycle();
    start = 1'b0;
  endtask

  // Run one op to completion. poke>0 raises a stray start during that cycle.
  task automatic run_op(input string tag, input alu_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic ill,
                        input int lat, input int poke);
    exp_t e;
    int   cyc;
    bit   got, busy_ok;
    logic ill1;
    sb.push_back('{res: res, ill: ill, lat: lat});
    start_op(op, a, b);
    cyc = 1; got = 0; busy_ok = 1; ill1 = 1'bx;
    while (cyc <= 60 && !got) begin
      @(negedge clk);
      if (cyc == 1) ill1 = illegal;
      if (busy !== 1'b1) busy_ok = 0;
      if (done === 1'b1) got = 1;
      else begin
        next_cycle();
        cyc++;
        start = (cyc == poke);
        if (cyc == poke) begin
          alu_op = ALU_MUL; oprnd_a = 32'd7; oprnd_b = 32'd6;
        end
      end
    end
    e = sb.pop_front();
    chk({tag, " done_seen"}, 32'(got), 32'd1);
    chk({tag, " latency"}, 32'(cyc), 32'(e.lat));
    chk({tag, " result"}, result, e.res);
    chk({tag, " illegal"}, 32'(illegal), 32'(e.ill));
    chk({tag, " busy_held"}, 32'(busy_ok), 32'd1);
    chk({tag, " illegal_cleared_on_start"}, 32'(ill1), 32'd0);
    next_cycle();
    start = 1'b0;
    @(negedge clk);
    chk({tag, " busy_after"}, 32'(busy), 32'd0);
    chk({tag, " done_after"}, 32'(done), 32'd0);
    last_res = e.res;
  endtask

  initial begin
    bit seen;

    // Reset state.
    repeat (3) next_cycle();
    @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst illegal", 32'(illegal), 32'd0);
    chk("rst result", result, 32'd0);
    next_cycle();
    rst = 1'b0;

    // Multiply.
    run_op("mul_7_6",   ALU_MUL,    32'd7,        32'd6,        32'h0000002A, 1'b0, 35, 0);
    run_op("mul_0_x",   ALU_MUL,    32'd0,        32'h12345678, 32'h00000000, 1'b0, 35, 0);
    run_op("mulh_m1",   ALU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 35, 0);
    run_op("mulhu_m1",  ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 35, 0);
    run_op("mulhsu_m1", ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 35, 0);
    run_op("mul_neg",   ALU_MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 1'b0, 35, 0);

    // Divide.
    run_op("div_m7_2",  ALU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 35, 0);
    run_op("rem_m7_2",  ALU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 35, 0);
    run_op("divu_100_7", ALU_DIVU,  32'd100,      32'd7,        32'd14,       1'b0, 35, 0);
    run_op("remu_100_7", ALU_REMU,  32'd100,      32'd7,        32'd2,        1'b0, 35, 0);

    // Special cases.
    run_op("div_by0",   ALU_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 3, 0);
    run_op("remu_by0",  ALU_REMU,   32'd5,        32'd0,        32'd5,        1'b0, 3, 0);
    run_op("div_ovf",   ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 3, 0);
    run_op("rem_ovf",   ALU_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 3, 0);

    // Start while busy is ignored; start during done is not accepted.
    run_op("divu_poke", ALU_DIVU,   32'd100,      32'd7,        32'd14,       1'b0, 35, 5);
    run_op("rem_poke_done", ALU_REMU, 32'd100,    32'd7,        32'd2,        1'b0, 35, 35);

    // Illegal op, then an M op must clear the flag.
    run_op("illegal_add", ALU_ADD,  32'd3,        32'd4,        32'd0,        1'b1, 3, 0);
    run_op("after_ill", ALU_DIVU,   32'd100,      32'd7,        32'd14,       1'b0, 35, 0);

    // Flush mid-divide.
    start_op(ALU_DIV, 32'd1000, 32'd3);
    repeat (9) next_cycle();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    chk("flush busy", 32'(busy), 32'd0);
    chk("flush result_kept", result, last_res);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    chk("flush no_done", 32'(seen), 32'd0);

    // Flush and start together: start dropped.
    next_cycle();
    start = 1'b1; flush = 1'b1; alu_op = ALU_MUL; oprnd_a = 32'd2; oprnd_b = 32'd3;
    next_cycle();
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_start busy", 32'(busy), 32'd0);

    // Reset at cycle 20 of a MUL.
    start_op(ALU_MUL, 32'd7, 32'd6);
    repeat (19) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid busy", 32'(busy), 32'd0);
    chk("rst_mid done", 32'(done), 32'd0);
    chk("rst_mid illegal", 32'(illegal), 32'd0);
    chk("rst_mid result", result, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    chk("rst_mid no_done", 32'(seen), 32'd0);

    // Engine still usable after reset.
    run_op("mul_after_rst", ALU_MUL, 32'd7, 32'd6, 32'h0000002A, 1'b0, 35, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
